fishing_game_engine: RTL and testbench
======================================

# fishing_game_engine

Parametrised game-logic core for the VGA fishing game. It owns the angler, line and fish positions, the per-level fish/catch state machine, scoring and win detection. It outputs registered object coordinates to a separate pixel renderer alongside `display_controller`. Compared with the fixed four-level controller, it has a configurable level count, shrinking fish geometry, escape-on-release and an optional miss limit.

## Interface
- `NUM_LEVELS`, 4: levels to clear before WIN (1–8).
- `FISH_SPEED`, 2: fish x step per tick, moving left.
- `LINE_DROP`, 4: line y step per tick, moving down.
- `REEL_STEP`, 2: fish/line y step per tick while reeling.
- `ROD_STEP`, 2: rod x step per tick.
- `ROD_MIN` / `ROD_MAX`, 312 / 798: rod x limits.
- `SCREEN_LEFT` / `SCREEN_RIGHT`, 144 / 798: fish wrap bounds.
- `WATER_Y` / `SURFACE_Y`, 155 / 105: line rest y / catch-complete y.
- `BASE_FISH_Y` / `LEVEL_Y_STEP`, 470 / 90: level-0 fish y / decrement per level.
- `BASE_FISH_W` / `BASE_FISH_HH`, 60 / 10: level-0 fish width / half-height.
- `MAX_MISSES`, 3: misses that end the game (macro builds only).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: game-step enable. State advances only on `clk` edges where `tick`=1.
- `up`, `down`, `left`, `right` in 1 each: debounced, level-sensitive buttons.
- `rod_x`, `line_y`, `fish_x`, `fish_y` out 10: object coordinates.
- `fish_w`, `fish_hh` out 10: current fish width and half-height.
- `level` out 3: current level, 0-based.
- `phase` out 2: 0 FISH, 1 CATCH, 2 WIN, 3 LOSE.
- `score` out 8: number of catches, saturating at 255.
- `misses` out 4: miss count.
- `level_done` out 1: one-cycle pulse when a level is completed.

## Operation
- Reset values:
  - `rod_x`=450, `line_y`=WATER_Y, `fish_x`=SCREEN_RIGHT, `fish_y`=BASE_FISH_Y.
  - `level`=0, `phase`=FISH, `score`=0, `misses`=0, `level_done`=0.
- Per-level geometry:
  - `fish_y` = BASE_FISH_Y − level·LEVEL_Y_STEP.
  - `fish_w` = BASE_FISH_W>>level, minimum 4.
  - `fish_hh` = BASE_FISH_HH>>level, minimum 1.
  - Hook window `hw` = `fish_w`>>2, minimum 1.
- FISH phase (each tick):
  - Fish moves: `fish_x` −= FISH_SPEED. If `fish_x` < SCREEN_LEFT+FISH_SPEED, it wraps to SCREEN_RIGHT and counts one miss.
  - Line drops: `line_y` += LINE_DROP, clamped at the current `fish_y`.
  - Rod moves: `right` has priority over `left`. The rod moves only if the result stays within ROD_MIN..ROD_MAX.
  - Hook: if `up` and `fish_x` ≤ `rod_x` ≤ `fish_x`+hw and |`line_y`−`fish_y`| ≤ `fish_hh`, go to CATCH. On that tick all positions freeze. Hook takes priority over wrap.
- CATCH phase (each tick):
  - While `up` is held: `fish_y` and `line_y` −= REEL_STEP.
  - If `up`=0: the fish escapes. Go to FISH with `fish_x`=SCREEN_RIGHT, `fish_y` back at the level's y, `line_y`=WATER_Y, misses +1.
  - When `fish_y` ≤ SURFACE_Y at the start of a tick: score +1 and pulse `level_done`.
    - If this was the last level (`level`=NUM_LEVELS−1): go to WIN.
    - Otherwise: `level` +1, FISH with fresh level geometry, `fish_x`=SCREEN_RIGHT, `line_y`=WATER_Y.
  - Surface check takes priority over release.
- WIN / LOSE: any button on a tick restores all reset values, except that `score` keeps its value in WIN.
- All arithmetic is unsigned 10-bit. Bound checks are written so no underflow or wrap occurs.

## Timing
- All outputs are registered. Effects appear on the `clk` edge that samples `tick`=1, so they are visible in the following cycle.
- `tick`=0: every register holds. `level_done` is 0.
- `rst` is synchronous and dominates `tick` and the buttons. Reset mid-CATCH or mid-WIN returns to reset values on the next edge.
- `level_done` is high for exactly one `clk` cycle per completed level.

## Configuration
- `FISH_MISS_LIMIT_EN` defined:
  - Enables LOSE. When `misses` reaches MAX_MISSES, the next tick enters LOSE and positions freeze.
  - `misses` saturates at 15.
- `FISH_MISS_LIMIT_EN` undefined:
  - LOSE is unreachable and `misses` is tied to 0.
  - Escapes and wraps reset the fish as above, with no count.

## Test plan
- Reset and idle: `rst` 1 cycle, then 10 ticks with no buttons. Expect `fish_x`=778, `line_y`=155+40=195, `phase`=0.
- Hook and reel level 0:
  - Rod at 450. Wait until the fish reaches `fish_x`=440 and the line rests at 470, then hold `up`.
  - Expect CATCH, then `fish_y` falling by 2 per tick.
  - At ≤105: `score`=1, single `level_done` pulse, `level`=1, `fish_y`=380, `fish_w`=30.
- Escape: release `up` mid-reel. Expect FISH, `fish_x`=798, `line_y`=155; `misses`=1 with the macro, 0 without.
- Full game: clear 4 levels. Expect `phase`=2 and `score`=4. Pressing `left` then restores `level`=0 with `score` still 4.
- Miss limit (macro): let the fish wrap 3 times. Expect `phase`=3 and frozen positions; the next button press resets.
- Rod bounds: hold `right` from 450. Expect `rod_x` to stop at 798, never beyond. `right`+`left` together moves right.

Source files
------------

// File: rtl/fishing_game_engine_if.sv
// Button/tick inputs and registered object state of the fishing game engine.
// The master side (game controller or bench) drives tick and buttons; the
// slave side (the engine) returns coordinates, geometry and game status.
interface fishing_game_engine_if;
    logic       tick;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [9:0] rod_x;
    logic [9:0] line_y;
    logic [9:0] fish_x;
    logic [9:0] fish_y;
    logic [9:0] fish_w;
    logic [9:0] fish_hh;
    logic [2:0] level;
    logic [1:0] phase;
    logic [7:0] score;
    logic [3:0] misses;
    logic       level_done;

    modport master (
        output tick, up, down, left, right,
        input  rod_x, line_y, fish_x, fish_y, fish_w, fish_hh,
        input  level, phase, score, misses, level_done
    );

    modport slave (
        input  tick, up, down, left, right,
        output rod_x, line_y, fish_x, fish_y, fish_w, fish_hh,
        output level, phase, score, misses, level_done
    );
endinterface

// File: rtl/fishing_game_engine.sv
// Game-logic core of the VGA fishing game: rod, line and fish positions,
// per-level fish/catch state machine, scoring and win detection.
// Optional feature macro: FISH_MISS_LIMIT_EN enables the miss counter and
// the LOSE phase after MAX_MISSES misses.
module fishing_game_engine #(
    parameter int NUM_LEVELS   = 4,
    parameter int FISH_SPEED   = 2,
    parameter int LINE_DROP    = 4,
    parameter int REEL_STEP    = 2,
    parameter int ROD_STEP     = 2,
    parameter int ROD_MIN      = 312,
    parameter int ROD_MAX      = 798,
    parameter int SCREEN_LEFT  = 144,
    parameter int SCREEN_RIGHT = 798,
    parameter int WATER_Y      = 155,
    parameter int SURFACE_Y    = 105,
    parameter int BASE_FISH_Y  = 470,
    parameter int LEVEL_Y_STEP = 90,
    parameter int BASE_FISH_W  = 60,
    parameter int BASE_FISH_HH = 10
`ifdef FISH_MISS_LIMIT_EN
    ,
    parameter int MAX_MISSES   = 3
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    fishing_game_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        PH_FISH  = 2'd0,
        PH_CATCH = 2'd1,
        PH_WIN   = 2'd2,
        PH_LOSE  = 2'd3
    } phase_t;

    localparam logic [9:0]  ROD_START     = 10'd450;
    localparam logic [9:0]  P_FISH_SPEED  = 10'(FISH_SPEED);
    localparam logic [9:0]  P_REEL_STEP   = 10'(REEL_STEP);
    localparam logic [9:0]  P_ROD_STEP    = 10'(ROD_STEP);
    localparam logic [9:0]  P_SCREEN_R    = 10'(SCREEN_RIGHT);
    localparam logic [9:0]  P_WRAP_LIM    = 10'(SCREEN_LEFT + FISH_SPEED);
    localparam logic [9:0]  P_WATER_Y     = 10'(WATER_Y);
    localparam logic [9:0]  P_SURFACE_Y   = 10'(SURFACE_Y);
    localparam logic [10:0] P_LINE_DROP11 = 11'(LINE_DROP);
    localparam logic [10:0] P_ROD_STEP11  = 11'(ROD_STEP);
    localparam logic [10:0] P_ROD_MAX11   = 11'(ROD_MAX);
    localparam logic [10:0] P_ROD_LMIN11  = 11'(ROD_MIN + ROD_STEP);
    localparam logic [2:0]  LAST_LEVEL    = 3'(NUM_LEVELS - 1);

    // Per-level geometry tables, constant-folded; fish y never goes below 0.
    logic [9:0] geom_y  [8];
    logic [9:0] geom_w  [8];
    logic [9:0] geom_hh [8];

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_geom
        localparam int         Y_DROP = gi * LEVEL_Y_STEP;
        localparam int         W_SH   = BASE_FISH_W >> gi;
        localparam int         HH_SH  = BASE_FISH_HH >> gi;
        localparam logic [9:0] GY     = (Y_DROP > BASE_FISH_Y) ? 10'd0 : 10'(BASE_FISH_Y - Y_DROP);
        localparam logic [9:0] GW     = (W_SH < 4) ? 10'd4 : 10'(W_SH);
        localparam logic [9:0] GHH    = (HH_SH < 1) ? 10'd1 : 10'(HH_SH);
        assign geom_y[gi]  = GY;
        assign geom_w[gi]  = GW;
        assign geom_hh[gi] = GHH;
    end

    logic [9:0] rod_x_reg, line_y_reg, fish_x_reg, fish_y_reg;
    logic [9:0] fish_w_reg, fish_hh_reg;
    logic [2:0] level_reg;
    phase_t     phase_reg;
    logic [7:0] score_reg;
    logic [3:0] misses_reg;
    logic       level_done_reg;

    // Hook window, vertical line-to-fish distance and bounded step results.
    logic [9:0]  hook_w;
    logic [9:0]  line_dist;
    logic        hook_hit;
    logic [10:0] line_sum;
    logic [10:0] rod_inc;
    logic [3:0]  misses_inc;
    logic        lose_now;
    logic        any_btn;
    logic        do_restore;
    logic [2:0]  level_inc;

    assign hook_w    = ((fish_w_reg >> 2) == 10'd0) ? 10'd1 : (fish_w_reg >> 2);
    assign line_dist = (line_y_reg >= fish_y_reg) ? (line_y_reg - fish_y_reg)
                                                  : (fish_y_reg - line_y_reg);
    assign hook_hit  = bus.up
                    && (rod_x_reg >= fish_x_reg)
                    && ({1'b0, rod_x_reg} <= ({1'b0, fish_x_reg} + {1'b0, hook_w}))
                    && (line_dist <= fish_hh_reg);
    assign line_sum  = {1'b0, line_y_reg} + P_LINE_DROP11;
    assign rod_inc   = {1'b0, rod_x_reg} + P_ROD_STEP11;
    assign any_btn   = bus.up | bus.down | bus.left | bus.right;
    assign level_inc = level_reg + 3'd1;
    assign do_restore = rst || (bus.tick && any_btn
                                && (phase_reg == PH_WIN || phase_reg == PH_LOSE));

`ifdef FISH_MISS_LIMIT_EN
    assign misses_inc = (misses_reg == 4'hF) ? 4'hF : (misses_reg + 4'd1);
    assign lose_now   = (misses_reg >= 4'(MAX_MISSES));
`else
    assign misses_inc = 4'd0;
    assign lose_now   = 1'b0;
`endif

    // Game state machine: all positions, status and the level_done pulse.
    always_ff @(posedge clk) begin
        level_done_reg <= 1'b0;
        if (do_restore) begin
            rod_x_reg   <= ROD_START;
            line_y_reg  <= P_WATER_Y;
            fish_x_reg  <= P_SCREEN_R;
            fish_y_reg  <= geom_y[0];
            fish_w_reg  <= geom_w[0];
            fish_hh_reg <= geom_hh[0];
            level_reg   <= 3'd0;
            phase_reg   <= PH_FISH;
            misses_reg  <= 4'd0;
            // A won game keeps its score across the restart.
            if (rst || phase_reg != PH_WIN)
                score_reg <= 8'd0;
        end else if (bus.tick) begin
            case (phase_reg)
                PH_FISH: begin
                    if (lose_now) begin
                        phase_reg <= PH_LOSE;
                    end else if (hook_hit) begin
                        phase_reg <= PH_CATCH;
                    end else begin
                        if (fish_x_reg < P_WRAP_LIM) begin
                            fish_x_reg <= P_SCREEN_R;
                            misses_reg <= misses_inc;
                        end else begin
                            fish_x_reg <= fish_x_reg - P_FISH_SPEED;
                        end
                        if (line_sum >= {1'b0, fish_y_reg})
                            line_y_reg <= fish_y_reg;
                        else
                            line_y_reg <= line_sum[9:0];
                        if (bus.right) begin
                            if (rod_inc <= P_ROD_MAX11)
                                rod_x_reg <= rod_inc[9:0];
                        end else if (bus.left) begin
                            if ({1'b0, rod_x_reg} >= P_ROD_LMIN11)
                                rod_x_reg <= rod_x_reg - P_ROD_STEP;
                        end
                    end
                end
                PH_CATCH: begin
                    if (fish_y_reg <= P_SURFACE_Y) begin
                        score_reg      <= (score_reg == 8'hFF) ? 8'hFF : (score_reg + 8'd1);
                        level_done_reg <= 1'b1;
                        if (level_reg == LAST_LEVEL) begin
                            phase_reg <= PH_WIN;
                        end else begin
                            level_reg   <= level_inc;
                            fish_y_reg  <= geom_y[level_inc];
                            fish_w_reg  <= geom_w[level_inc];
                            fish_hh_reg <= geom_hh[level_inc];
                            fish_x_reg  <= P_SCREEN_R;
                            line_y_reg  <= P_WATER_Y;
                            phase_reg   <= PH_FISH;
                        end
                    end else if (bus.up) begin
                        fish_y_reg <= (fish_y_reg >= P_REEL_STEP) ? (fish_y_reg - P_REEL_STEP) : 10'd0;
                        line_y_reg <= (line_y_reg >= P_REEL_STEP) ? (line_y_reg - P_REEL_STEP) : 10'd0;
                    end else begin
                        // Released: the fish escapes and the level restarts.
                        fish_x_reg <= P_SCREEN_R;
                        fish_y_reg <= geom_y[level_reg];
                        line_y_reg <= P_WATER_Y;
                        misses_reg <= misses_inc;
                        phase_reg  <= PH_FISH;
                    end
                end
                default: begin
                    // WIN / LOSE hold until a button press restores the game.
                end
            endcase
        end
    end

    assign bus.rod_x      = rod_x_reg;
    assign bus.line_y     = line_y_reg;
    assign bus.fish_x     = fish_x_reg;
    assign bus.fish_y     = fish_y_reg;
    assign bus.fish_w     = fish_w_reg;
    assign bus.fish_hh    = fish_hh_reg;
    assign bus.level      = level_reg;
    assign bus.phase      = phase_reg;
    assign bus.score      = score_reg;
    assign bus.misses     = misses_reg;
    assign bus.level_done = level_done_reg;

endmodule

// File: tb/tb_fishing_game_engine.sv
// Directed bench for fishing_game_engine: reset, idle drift, hook and reel,
// escape, full game to WIN, miss limit and rod bounds.
module tb_fishing_game_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fishing_game_engine_if bus_if ();

    fishing_game_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FISH_MISS_LIMIT_EN
    localparam int EXP_ESC_MISS  = 1;
    localparam int EXP_LIM_PHASE = 3;
    localparam int EXP_LIM_MISS  = 3;
    localparam int EXP_LIM_X0    = 798;
    localparam int EXP_LIM_X1    = 798;
`else
    localparam int EXP_ESC_MISS  = 0;
    localparam int EXP_LIM_PHASE = 0;
    localparam int EXP_LIM_MISS  = 0;
    localparam int EXP_LIM_X0    = 796;
    localparam int EXP_LIM_X1    = 794;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("  ok   %s = %0d", tag, obs);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic t, input logic u, input logic d,
                        input logic l, input logic r);
        @(negedge clk);
        bus_if.tick  = t;
        bus_if.up    = u;
        bus_if.down  = d;
        bus_if.left  = l;
        bus_if.right = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fish(input int target, input int limit);
        int n = 0;
        while (int'(bus_if.fish_x) != target && n < limit) begin
            step(1, 0, 0, 0, 0);
            n++;
        end
        check("reach_fish_x", int'(bus_if.fish_x), target);
    endtask

    task automatic play_level(input int next_level);
        int n = 0;
        wait_fish(450, 400);
        step(1, 1, 0, 0, 0);
        check("hook_phase", int'(bus_if.phase), 1);
        while (!bus_if.level_done && n < 300) begin
            step(1, 1, 0, 0, 0);
            n++;
        end
        check("level_done", int'(bus_if.level_done), 1);
        check("level_after", int'(bus_if.level), next_level);
        step(0, 0, 0, 0, 0);
        check("level_done_pulse", int'(bus_if.level_done), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus_if.tick = 0; bus_if.up = 0; bus_if.down = 0;
        bus_if.left = 0; bus_if.right = 0;
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset state
        check("rst_rod_x",  int'(bus_if.rod_x), 450);
        check("rst_line_y", int'(bus_if.line_y), 155);
        check("rst_fish_x", int'(bus_if.fish_x), 798);
        check("rst_fish_y", int'(bus_if.fish_y), 470);
        check("rst_fish_w", int'(bus_if.fish_w), 60);
        check("rst_fish_hh", int'(bus_if.fish_hh), 10);
        check("rst_level",  int'(bus_if.level), 0);
        check("rst_phase",  int'(bus_if.phase), 0);
        check("rst_score",  int'(bus_if.score), 0);
        check("rst_misses", int'(bus_if.misses), 0);
        check("rst_level_done", int'(bus_if.level_done), 0);

        // tick=0 holds everything even with a button down
        step(0, 0, 0, 0, 1);
        check("hold_rod_x", int'(bus_if.rod_x), 450);
        check("hold_fish_x", int'(bus_if.fish_x), 798);

        // Idle: 10 ticks
        repeat (10) step(1, 0, 0, 0, 0);
        check("idle_fish_x", int'(bus_if.fish_x), 778);
        check("idle_line_y", int'(bus_if.line_y), 195);
        check("idle_phase",  int'(bus_if.phase), 0);

        // Hook and reel level 0
        wait_fish(440, 400);
        check("l0_line_rest", int'(bus_if.line_y), 470);
        step(1, 1, 0, 0, 0);
        check("l0_hook_phase", int'(bus_if.phase), 1);
        check("l0_hook_fish_x", int'(bus_if.fish_x), 440);
        check("l0_hook_fish_y", int'(bus_if.fish_y), 470);
        step(1, 1, 0, 0, 0);
        check("l0_reel_fish_y", int'(bus_if.fish_y), 468);
        check("l0_reel_line_y", int'(bus_if.line_y), 468);
        n = 0;
        while (!bus_if.level_done && n < 300) begin
            step(1, 1, 0, 0, 0);
            n++;
        end
        check("l0_reel_ticks", n, 183);
        check("l0_score",  int'(bus_if.score), 1);
        check("l0_level",  int'(bus_if.level), 1);
        check("l0_fish_y", int'(bus_if.fish_y), 380);
        check("l0_fish_w", int'(bus_if.fish_w), 30);
        check("l0_fish_hh", int'(bus_if.fish_hh), 5);
        check("l0_fish_x", int'(bus_if.fish_x), 798);
        check("l0_line_y", int'(bus_if.line_y), 155);
        check("l0_phase",  int'(bus_if.phase), 0);
        step(0, 0, 0, 0, 0);
        check("l0_done_pulse", int'(bus_if.level_done), 0);

        // Escape mid-reel on level 1
        wait_fish(450, 400);
        step(1, 1, 0, 0, 0);
        check("esc_hook_phase", int'(bus_if.phase), 1);
        repeat (5) step(1, 1, 0, 0, 0);
        check("esc_reel_fish_y", int'(bus_if.fish_y), 370);
        step(1, 0, 0, 0, 0);
        check("esc_phase",  int'(bus_if.phase), 0);
        check("esc_fish_x", int'(bus_if.fish_x), 798);
        check("esc_fish_y", int'(bus_if.fish_y), 380);
        check("esc_line_y", int'(bus_if.line_y), 155);
        check("esc_misses", int'(bus_if.misses), EXP_ESC_MISS);
        check("esc_score",  int'(bus_if.score), 1);

        // Clear levels 1..3 to WIN
        play_level(2);
        check("l2_fish_w", int'(bus_if.fish_w), 15);
        play_level(3);
        check("l3_fish_y", int'(bus_if.fish_y), 200);
        check("l3_fish_hh", int'(bus_if.fish_hh), 1);
        play_level(3);
        check("win_phase", int'(bus_if.phase), 2);
        check("win_score", int'(bus_if.score), 4);
        step(0, 0, 0, 1, 0);
        check("win_hold_phase", int'(bus_if.phase), 2);
        step(1, 0, 0, 1, 0);
        check("win_rst_phase", int'(bus_if.phase), 0);
        check("win_rst_level", int'(bus_if.level), 0);
        check("win_rst_score", int'(bus_if.score), 4);
        check("win_rst_rod_x", int'(bus_if.rod_x), 450);
        check("win_rst_fish_x", int'(bus_if.fish_x), 798);
        check("win_rst_fish_w", int'(bus_if.fish_w), 60);
        check("win_rst_misses", int'(bus_if.misses), 0);

        // Three wraps (328 ticks each), then one more tick
        repeat (985) step(1, 0, 0, 0, 0);
        check("lim_phase",  int'(bus_if.phase), EXP_LIM_PHASE);
        check("lim_misses", int'(bus_if.misses), EXP_LIM_MISS);
        check("lim_fish_x", int'(bus_if.fish_x), EXP_LIM_X0);
        step(1, 0, 0, 0, 0);
        check("lim_fish_x_next", int'(bus_if.fish_x), EXP_LIM_X1);
`ifdef FISH_MISS_LIMIT_EN
        step(1, 0, 1, 0, 0);
        check("lose_rst_phase", int'(bus_if.phase), 0);
        check("lose_rst_score", int'(bus_if.score), 0);
        check("lose_rst_misses", int'(bus_if.misses), 0);
`endif

        // Reset dominates tick and buttons
        rst = 1'b1;
        step(1, 0, 0, 0, 1);
        rst = 1'b0;
        check("rstdom_rod_x", int'(bus_if.rod_x), 450);
        check("rstdom_score", int'(bus_if.score), 0);
        check("rstdom_fish_x", int'(bus_if.fish_x), 798);

        // Rod: right beats left, then stop at ROD_MAX
        step(1, 0, 0, 1, 1);
        check("rod_both", int'(bus_if.rod_x), 452);
        n = 0;
        while (int'(bus_if.rod_x) != 798 && n < 400) begin
            step(1, 0, 0, 0, 1);
            n++;
        end
        check("rod_ticks_to_max", n, 173);
        repeat (3) step(1, 0, 0, 0, 1);
        check("rod_max_hold", int'(bus_if.rod_x), 798);
        step(1, 0, 0, 1, 0);
        check("rod_left", int'(bus_if.rod_x), 796);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
